// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency, single-ported memory between instruction fetch
// and load/store. Data has priority; a starvation counter forces fetch after a run of data grants.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [31:0]           if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [31:0]           d_wdata_i,
  input  logic [3:0]            d_be_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [31:0]           d_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic [31:0]           mem_rdata_i
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_D = 2'd2} owner_t;

  state_t             state_r;
  owner_t             owner_r;
  logic               owner_we_r;
  logic [LAT_W-1:0]   lat_cnt_r;
  logic [STV_W-1:0]   starve_cnt_r;
  logic               last_s;
  logic               free_s;
  logic               force_if_s;
  logic               d_win_s;
  logic               if_win_s;

  // Winner selection; the final busy cycle overlaps the next grant for full throughput
  always_comb begin
    last_s     = (state_r == BUSY) && (lat_cnt_r == LAT_LAST);
    free_s     = rst_ni && ((state_r == IDLE) || last_s);
    force_if_s = if_req_i && (starve_cnt_r == STV_MAX);
    d_win_s    = free_s && d_req_i && !force_if_s;
    if_win_s   = free_s && if_req_i && !d_win_s;
  end

  // Memory request path, driven only in a grant cycle
  always_comb begin
    if_gnt_o    = if_win_s;
    d_gnt_o     = d_win_s;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = {ADDR_WIDTH{1'b0}};
    mem_wdata_o = 32'h0000_0000;
    mem_be_o    = 4'h0;
    if (d_win_s) begin
      mem_req_o   = 1'b1;
      mem_we_o    = d_we_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      mem_be_o    = d_be_i;
    end else if (if_win_s) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b0;
      mem_addr_o  = if_addr_i;
      mem_wdata_o = 32'h0000_0000;
      mem_be_o    = 4'hF;
    end else begin
      mem_req_o   = 1'b0;
    end
  end

  // Response routing to the latched owner; store acks carry zero data
  always_comb begin
    if_rvalid_o = 1'b0;
    if_rdata_o  = 32'h0000_0000;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = 32'h0000_0000;
    if (last_s && (owner_r == OWN_IF)) begin
      if_rvalid_o = 1'b1;
      if_rdata_o  = mem_rdata_i;
    end else if (last_s && (owner_r == OWN_D)) begin
      d_rvalid_o  = 1'b1;
      d_rdata_o   = owner_we_r ? 32'h0000_0000 : mem_rdata_i;
    end else begin
      d_rvalid_o  = 1'b0;
    end
  end

  // Transaction FSM: owner capture and latency counting
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      owner_r    <= OWN_NONE;
      owner_we_r <= 1'b0;
      lat_cnt_r  <= {LAT_W{1'b0}};
    end else if (d_win_s || if_win_s) begin
      state_r    <= BUSY;
      owner_r    <= d_win_s ? OWN_D : OWN_IF;
      owner_we_r <= d_win_s && d_we_i;
      lat_cnt_r  <= {LAT_W{1'b0}};
    end else begin
      case (state_r)
        BUSY: begin
          if (last_s) begin
            state_r    <= IDLE;
            owner_r    <= OWN_NONE;
            owner_we_r <= 1'b0;
            lat_cnt_r  <= {LAT_W{1'b0}};
          end else begin
            lat_cnt_r  <= lat_cnt_r + LAT_W'(1);
          end
        end
        IDLE:    lat_cnt_r <= {LAT_W{1'b0}};
        default: state_r   <= IDLE;
      endcase
    end
  end

  // Starvation guard: counts data grants that bypassed a waiting fetch
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_r <= {STV_W{1'b0}};
    end else if (!if_req_i || if_win_s) begin
      starve_cnt_r <= {STV_W{1'b0}};
    end else if (d_win_s && (starve_cnt_r != STV_MAX)) begin
      starve_cnt_r <= starve_cnt_r + STV_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: MEM_LAT=2 instance (a_*) and MEM_LAT=1 instance (b_*).
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_if_req, a_if_gnt, a_if_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
  logic [15:0] a_if_addr, a_d_addr, a_mem_addr;
  logic [31:0] a_if_rdata, a_d_wdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_d_be, a_mem_be;
  logic        a_mem_req, a_mem_we;

  logic        b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
  logic [15:0] b_if_addr, b_d_addr, b_mem_addr;
  logic [31:0] b_if_rdata, b_d_wdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_d_be, b_mem_be;
  logic        b_mem_req, b_mem_we;

  mem_arbiter #(.ADDR_WIDTH(16), .MEM_LAT(2), .STARVE_MAX(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(a_if_req), .if_addr_i(a_if_addr), .if_gnt_o(a_if_gnt),
    .if_rvalid_o(a_if_rvalid), .if_rdata_o(a_if_rdata),
    .d_req_i(a_d_req), .d_we_i(a_d_we), .d_addr_i(a_d_addr), .d_wdata_i(a_d_wdata),
    .d_be_i(a_d_be), .d_gnt_o(a_d_gnt), .d_rvalid_o(a_d_rvalid), .d_rdata_o(a_d_rdata),
    .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
    .mem_wdata_o(a_mem_wdata), .mem_be_o(a_mem_be), .mem_rdata_i(a_mem_rdata));

  mem_arbiter #(.ADDR_WIDTH(16), .MEM_LAT(1), .STARVE_MAX(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_gnt_o(b_if_gnt),
    .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata),
    .d_req_i(b_d_req), .d_we_i(b_d_we), .d_addr_i(b_d_addr), .d_wdata_i(b_d_wdata),
    .d_be_i(b_d_be), .d_gnt_o(b_d_gnt), .d_rvalid_o(b_d_rvalid), .d_rdata_o(b_d_rdata),
    .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
    .mem_wdata_o(b_mem_wdata), .mem_be_o(b_mem_be), .mem_rdata_i(b_mem_rdata));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=no_event required=event_within_bound", name);
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } gnt_t;

  gnt_t        a_gnt_q[$];
  gnt_t        b_gnt_q[$];
  logic [31:0] a_if_rsp_q[$], a_d_rsp_q[$], b_if_rsp_q[$], b_d_rsp_q[$];
  int          a_if_cyc_q[$], a_d_cyc_q[$], b_if_cyc_q[$], b_d_cyc_q[$];

  // Memory model for instance A: 2-cycle read pipeline with byte-enabled writes
  logic [31:0] mem_a [0:255];
  logic [31:0] a_rd1, a_rd2;
  always @(posedge clk) begin
    if (a_mem_req && a_mem_we)
      for (int i = 0; i < 4; i++)
        if (a_mem_be[i]) mem_a[a_mem_addr[9:2]][8*i +: 8] <= a_mem_wdata[8*i +: 8];
    a_rd1 <= a_mem_req ? mem_a[a_mem_addr[9:2]] : 32'hBAD0_BAD0;
    a_rd2 <= a_rd1;
  end
  assign a_mem_rdata = a_rd2;

  // Memory model for instance B: 1-cycle read returning an address tag
  logic [31:0] b_rd1;
  always @(posedge clk) b_rd1 <= b_mem_req ? {16'hB000, b_mem_addr} : 32'h0BAD_0BAD;
  assign b_mem_rdata = b_rd1;

  gnt_t ga;
  // Monitor A: pops expectations on every grant / response
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("a_reset_outs", 32'({a_if_gnt, a_d_gnt, a_if_rvalid, a_d_rvalid, a_mem_req, a_mem_we}), 32'h0);
    end else begin
      if (a_if_gnt && a_d_gnt) chk("a_dual_gnt", 32'({a_if_gnt, a_d_gnt}), 32'h2);
      if (a_if_gnt || a_d_gnt) begin
        if (a_gnt_q.size() == 0) chk("a_unexp_gnt", 32'({a_if_gnt, a_d_gnt}), 32'h0);
        else begin
          ga = a_gnt_q.pop_front();
          chk("a_gnt_owner", 32'({a_if_gnt, a_d_gnt}), ga.is_d ? 32'h1 : 32'h2);
          chk("a_mem_req", 32'(a_mem_req), 32'h1);
          chk("a_mem_we", 32'(a_mem_we), 32'(ga.we));
          chk("a_mem_addr", 32'(a_mem_addr), 32'(ga.addr));
          chk("a_mem_be", 32'(a_mem_be), 32'(ga.be));
          if (ga.is_d) chk("a_mem_wdata", a_mem_wdata, ga.wdata);
          if (a_d_gnt) a_d_cyc_q.push_back(cyc); else a_if_cyc_q.push_back(cyc);
        end
      end else begin
        chk("a_idle_mem", 32'({a_mem_req, a_mem_we, a_mem_be, a_mem_addr}), 32'h0);
        chk("a_idle_wdata", a_mem_wdata, 32'h0);
      end
      if (a_if_rvalid) begin
        if (a_if_rsp_q.size() == 0 || a_if_cyc_q.size() == 0) chk("a_unexp_if_rvalid", 32'(a_if_rvalid), 32'h0);
        else begin
          chk("a_if_rdata", a_if_rdata, a_if_rsp_q.pop_front());
          chk("a_if_latency", 32'(cyc - a_if_cyc_q.pop_front()), 32'd2);
        end
      end else chk("a_if_rdata_idle", a_if_rdata, 32'h0);
      if (a_d_rvalid) begin
        if (a_d_rsp_q.size() == 0 || a_d_cyc_q.size() == 0) chk("a_unexp_d_rvalid", 32'(a_d_rvalid), 32'h0);
        else begin
          chk("a_d_rdata", a_d_rdata, a_d_rsp_q.pop_front());
          chk("a_d_latency", 32'(cyc - a_d_cyc_q.pop_front()), 32'd2);
        end
      end else chk("a_d_rdata_idle", a_d_rdata, 32'h0);
    end
  end

  gnt_t gb;
  // Monitor B: same scoreboard discipline, one-cycle latency
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_if_gnt || b_d_gnt) begin
        if (b_gnt_q.size() == 0) chk("b_unexp_gnt", 32'({b_if_gnt, b_d_gnt}), 32'h0);
        else begin
          gb = b_gnt_q.pop_front();
          chk("b_gnt_owner", 32'({b_if_gnt, b_d_gnt}), gb.is_d ? 32'h1 : 32'h2);
          chk("b_mem_addr", 32'(b_mem_addr), 32'(gb.addr));
          if (b_d_gnt) b_d_cyc_q.push_back(cyc); else b_if_cyc_q.push_back(cyc);
        end
      end
      if (b_if_rvalid) begin
        if (b_if_rsp_q.size() == 0 || b_if_cyc_q.size() == 0) chk("b_unexp_if_rvalid", 32'(b_if_rvalid), 32'h0);
        else begin
          chk("b_if_rdata", b_if_rdata, b_if_rsp_q.pop_front());
          chk("b_if_latency", 32'(cyc - b_if_cyc_q.pop_front()), 32'd1);
        end
      end else chk("b_if_rdata_idle", b_if_rdata, 32'h0);
      if (b_d_rvalid) begin
        if (b_d_rsp_q.size() == 0 || b_d_cyc_q.size() == 0) chk("b_unexp_d_rvalid", 32'(b_d_rvalid), 32'h0);
        else begin
          chk("b_d_rdata", b_d_rdata, b_d_rsp_q.pop_front());
          chk("b_d_latency", 32'(cyc - b_d_cyc_q.pop_front()), 32'd1);
        end
      end else chk("b_d_rdata_idle", b_d_rdata, 32'h0);
    end
  end

  task automatic a_wait_gnt(input bit is_d, input string name, output int gc);
    int n;
    n  = 0;
    gc = -1;
    while (gc < 0 && n < 40) begin
      @(negedge clk);
      n++;
      if ((is_d && a_d_gnt) || (!is_d && a_if_gnt)) gc = cyc;
    end
    if (gc < 0) timeout(name);
  endtask

  task automatic a_issue(input bit is_d, input bit we, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input bit has_rsp, input logic [31:0] rsp, output int gc);
    gnt_t g;
    g.is_d = is_d; g.we = we; g.addr = addr; g.wdata = wdata; g.be = is_d ? be : 4'hF;
    a_gnt_q.push_back(g);
    if (is_d) begin
      if (has_rsp) a_d_rsp_q.push_back(rsp);
      a_d_req = 1'b1; a_d_we = we; a_d_addr = addr; a_d_wdata = wdata; a_d_be = be;
    end else begin
      if (has_rsp) a_if_rsp_q.push_back(rsp);
      a_if_req = 1'b1; a_if_addr = addr;
    end
    a_wait_gnt(is_d, "a_gnt_timeout", gc);
    @(posedge clk); #1;
    if (is_d) a_d_req = 1'b0; else a_if_req = 1'b0;
  endtask

  initial begin
    int gs, gl, gc, t, s, n, cnt, f1, f2;
    gnt_t g;
    for (int i = 0; i < 256; i++) mem_a[i] = 32'hC0DE_0000 | 32'(i);
    mem_a[4]  = 32'h0050_0093;
    mem_a[64] = 32'h1122_3344;
    a_if_req = 1'b0; a_if_addr = 16'h0; a_d_req = 1'b0; a_d_we = 1'b0;
    a_d_addr = 16'h0; a_d_wdata = 32'h0; a_d_be = 4'h0;
    b_if_req = 1'b0; b_if_addr = 16'h0; b_d_req = 1'b0; b_d_we = 1'b0;
    b_d_addr = 16'h0; b_d_wdata = 32'h0; b_d_be = 4'hF;

    // Reset with both requests pending: data must win on the first edge after release
    rst_n = 1'b0;
    a_d_req = 1'b1; a_d_addr = 16'h0020; a_d_be = 4'hF;
    a_if_req = 1'b1; a_if_addr = 16'h0024;
    g.is_d = 1'b1; g.we = 1'b0; g.addr = 16'h0020; g.wdata = 32'h0; g.be = 4'hF;
    a_gnt_q.push_back(g);
    g.is_d = 1'b0; g.addr = 16'h0024;
    a_gnt_q.push_back(g);
    a_d_rsp_q.push_back(32'hC0DE_0008);
    a_if_rsp_q.push_back(32'hC0DE_0009);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    t = cyc;
    a_wait_gnt(1'b1, "rst_release_gnt_timeout", gc);
    chk("first_gnt_after_reset", 32'(gc - t), 32'd0);
    @(posedge clk); #1 a_d_req = 1'b0;
    a_wait_gnt(1'b0, "rst_fetch_gnt_timeout", gc);
    @(posedge clk); #1 a_if_req = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Lone fetch
    a_issue(1'b0, 1'b0, 16'h0010, 32'h0, 4'hF, 1'b1, 32'h0050_0093, gc);
    repeat (3) @(posedge clk); #1;

    // Store then back-to-back load to the same word
    a_issue(1'b1, 1'b1, 16'h0100, 32'hDEAD_BEEF, 4'b0011, 1'b1, 32'h0000_0000, gs);
    a_issue(1'b1, 1'b0, 16'h0100, 32'h0, 4'hF, 1'b1, 32'h1122_BEEF, gl);
    chk("b2b_load_gnt_gap", 32'(gl - gs), 32'd2);
    repeat (3) @(posedge clk); #1;

    // Contention: 4 data grants then a forced fetch, twice
    for (int k = 0; k < 10; k++) begin
      g.is_d = ((k % 5) != 4); g.we = 1'b0; g.wdata = 32'h0; g.be = 4'hF;
      g.addr = g.is_d ? 16'h0200 : 16'h0300;
      a_gnt_q.push_back(g);
      if (g.is_d) a_d_rsp_q.push_back(32'hC0DE_0080); else a_if_rsp_q.push_back(32'hC0DE_00C0);
    end
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 16'h0200; a_d_wdata = 32'h0; a_d_be = 4'hF;
    a_if_req = 1'b1; a_if_addr = 16'h0300;
    s = cyc; n = 0; cnt = 0; f1 = -1; f2 = -1;
    while (cnt < 10 && n < 80) begin
      @(negedge clk);
      n++;
      if (a_if_gnt || a_d_gnt) begin
        cnt++;
        if (a_if_gnt) begin
          if (f1 < 0) f1 = cyc; else f2 = cyc;
        end
      end
    end
    @(posedge clk); #1;
    a_d_req = 1'b0; a_if_req = 1'b0;
    if (cnt < 10) timeout("contention_grants");
    chk("fetch_first_wait", 32'(f1 - s), 32'd8);
    chk("fetch_period", 32'(f2 - f1), 32'd10);
    repeat (4) @(posedge clk); #1;

    // Reset one cycle after a fetch grant: the response must never appear
    g.is_d = 1'b0; g.we = 1'b0; g.addr = 16'h0010; g.wdata = 32'h0; g.be = 4'hF;
    a_gnt_q.push_back(g);
    a_if_req = 1'b1; a_if_addr = 16'h0010;
    a_wait_gnt(1'b0, "midop_gnt_timeout", gc);
    @(posedge clk); #1;
    a_if_req = 1'b0;
    rst_n = 1'b0;
    a_if_cyc_q.delete();
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    t = cyc;
    a_issue(1'b1, 1'b0, 16'h0020, 32'h0, 4'hF, 1'b1, 32'hC0DE_0008, gc);
    chk("post_reset_gnt_immediate", 32'(gc - t), 32'd0);
    repeat (4) @(posedge clk); #1;

    // MEM_LAT=1 instance: alternating data/fetch, one grant per cycle
    for (int k = 0; k < 8; k++) begin
      g.is_d = ((k % 2) == 0); g.we = 1'b0; g.wdata = 32'h0; g.be = 4'hF;
      g.addr = 16'(16'h0040 + 16'(k * 4));
      b_gnt_q.push_back(g);
      if (g.is_d) begin
        b_d_rsp_q.push_back({16'hB000, g.addr});
        b_d_req = 1'b1; b_if_req = 1'b0; b_d_addr = g.addr;
      end else begin
        b_if_rsp_q.push_back({16'hB000, g.addr});
        b_if_req = 1'b1; b_d_req = 1'b0; b_if_addr = g.addr;
      end
      @(posedge clk); #1;
    end
    b_d_req = 1'b0; b_if_req = 1'b0;
    repeat (5) @(posedge clk); #1;

    chk("a_gnt_q_drained", 32'(a_gnt_q.size()), 32'd0);
    chk("a_rsp_q_drained", 32'(a_if_rsp_q.size() + a_d_rsp_q.size()), 32'd0);
    chk("b_gnt_q_drained", 32'(b_gnt_q.size()), 32'd0);
    chk("b_rsp_q_drained", 32'(b_if_rsp_q.size() + b_d_rsp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
